// File: rtl/countdown_especial.sv
// ----------------------------------------------------------------------------
// countdown_especial
//   Loadable down-counter (timer) with a selectable step of 1 or 2.
//   A start request loads load_val. The counter then decrements once per cycle
//   until it saturates at zero, and a one-cycle done pulse follows.
//   Typical use is as a delay or timeout generator.
//
// Ports
//   clk       in   1      clock, all state changes on posedge
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      load load_val and begin counting
//   load_val  in   WIDTH  unsigned start value
//   ctrl      in   1      step select: 1 -> step 2, 0 -> step 1
//   pause     in   1      hold the count while running
//   count     out  WIDTH  current counter value
//   busy      out  1      high while running
//   done      out  1      high for the single cycle after reaching zero
// ----------------------------------------------------------------------------
module countdown_especial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ctrl,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_step;

    assign w_step = ctrl ? WIDTH'(2) : WIDTH'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next-state logic. A start request takes the same path from every state.
    // A zero load goes straight to DONE, so busy never rises for it.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_count_next = load_val;
                    w_state_next = (load_val != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    w_count_next = load_val;
                    w_state_next = (load_val != '0) ? ST_RUN : ST_DONE;
                end else if (pause) begin
                    w_count_next = r_count;
                end else if (r_count > w_step) begin
                    w_count_next = r_count - w_step;
                end else begin
                    // The comparison is made before subtracting, so a count
                    // of 1 with step 2 lands on zero and does not wrap.
                    w_count_next = '0;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_count_next = '0;
                w_state_next = ST_IDLE;
                if (start) begin
                    w_count_next = load_val;
                    w_state_next = (load_val != '0) ? ST_RUN : ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    // Moore outputs
    assign count = r_count;
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_countdown_especial.sv
module tb_countdown_especial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] load_val;
    logic       ctrl;
    logic       pause;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    countdown_especial #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .ctrl     (ctrl),
        .pause    (pause),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] lv;
        logic       ctrl;
        logic       pause;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add(input logic s, input int lv, input logic c, input logic p,
                                input int cnt, input logic b, input logic d);
        vec_t v;
        v.start = s;
        v.lv    = 4'(lv);
        v.ctrl  = c;
        v.pause = p;
        v.cnt   = 4'(cnt);
        v.busy  = b;
        v.done  = d;
        vecs.push_back(v);
    endfunction

    task automatic check_now(input string name, input logic [3:0] ec, input logic eb, input logic ed);
        n_tests++;
        if (count !== ec || busy !== eb || done !== ed) begin
            n_fail++;
            $display("FAIL %s: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     name, count, busy, done, ec, eb, ed);
        end else begin
            $display("[TB] %s: count=%0d busy=%b done=%b ok", name, count, busy, done);
        end
    endtask

    // Scoreboard monitor: pops one expectation per clock edge that had stimulus
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_now($sformatf("vec%0d", e.idx), e.cnt, e.busy, e.done);
        end
    end

    // Drive inputs for the next edge and record what must come out of it
    task automatic drive(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        start    = v.start;
        load_val = v.lv;
        ctrl     = v.ctrl;
        pause    = v.pause;
        e.idx  = idx;
        e.cnt  = v.cnt;
        e.busy = v.busy;
        e.done = v.done;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; load_val = 4'd0; ctrl = 1'b0; pause = 1'b0;

        // Release from reset, outputs remain zero
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 7, 1, 0, 0, 0, 0);
        // Load 5, step 1
        add(1, 5, 0, 0, 5, 1, 0);
        add(0, 0, 0, 0, 4, 1, 0);
        add(0, 0, 0, 0, 3, 1, 0);
        add(0, 0, 0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Load 5, step 2: saturates from 1 to 0
        add(1, 5, 1, 0, 5, 1, 0);
        add(0, 0, 1, 0, 3, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0);
        // Load 0: straight to done, never busy
        add(1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Load 9, pause at 6, then reload 2 while paused
        add(1, 9, 0, 0, 9, 1, 0);
        add(0, 0, 0, 0, 8, 1, 0);
        add(0, 0, 0, 0, 7, 1, 0);
        add(0, 0, 0, 0, 6, 1, 0);
        add(0, 0, 0, 1, 6, 1, 0);
        add(0, 0, 0, 1, 6, 1, 0);
        add(0, 0, 0, 1, 6, 1, 0);
        add(0, 0, 0, 0, 5, 1, 0);
        add(0, 0, 0, 0, 4, 1, 0);
        add(1, 2, 0, 1, 2, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Load 2 with step 2, then a back-to-back start during DONE
        add(1, 2, 1, 0, 2, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(1, 3, 0, 0, 3, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Load 1 with step 2: no underflow
        add(1, 1, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Load 15, step 2 for two cycles, then step 1, down to 7
        add(1, 15, 1, 0, 15, 1, 0);
        add(0, 0, 1, 0, 13, 1, 0);
        add(0, 0, 1, 0, 11, 1, 0);
        add(0, 0, 0, 0, 10, 1, 0);
        add(0, 0, 0, 0, 9, 1, 0);
        add(0, 0, 0, 0, 8, 1, 0);
        add(0, 0, 0, 0, 7, 1, 0);

        // Reset state, checked while rst is held across edges
        #3;
        check_now("reset_t3", 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_now("reset_held", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) drive(i, vecs[i]);

        // Asynchronous reset in the middle of a cycle, with count at 7
        @(posedge clk); #3;
        start = 1'b0; ctrl = 1'b0; pause = 1'b0;
        rst = 1'b1;
        #1;
        check_now("async_rst_now", 4'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        begin
            vec_t v;
            v.start = 0; v.lv = 4'd9; v.ctrl = 0; v.pause = 0;
            v.cnt = 4'd0; v.busy = 0; v.done = 0;
            drive(100, v);
            drive(101, v);
        end
        @(posedge clk); #3;

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
